// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
//  Module   : fetch (plus fetch_pkg carrying the decode-facing struct)
//  Purpose  : Stage-1 instruction fetch. Owns the PC and issues word-aligned
//             requests on a valid/ready instruction-memory port, with one
//             request outstanding at a time. Fetched words go to decode as
//             f_out (instruction address) plus instr_dat_out. Redirects from
//             execute replace the PC, and any response that is already in
//             flight is discarded.
//  Ports    : clk, rst_n (async, active-low)
//             stall_in                   - downstream hold, outputs frozen
//             redirect_en/redirect_addr  - taken branch/jump from execute
//             imem_req_valid/ready/addr  - request channel (addr = PC)
//             imem_rsp_valid/data        - in-order responses
//             f_out, instr_dat_out       - instruction presented to decode
//             stall_out                  - 1 = outputs carry a bubble
//             perf_fetch_cnt/perf_bubble_cnt - only with FETCH_PERF_CNT_EN
//  Macro    : FETCH_PERF_CNT_EN adds wrapping valid/bubble load counters.
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;
    typedef struct packed {
        logic [31:0] instr_addr;
    } f_d_WI;
endpackage

module fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_in,
    input  logic              redirect_en,
    input  logic [31:0]       redirect_addr,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [31:0]       imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output fetch_pkg::f_d_WI  f_out,
    output logic [31:0]       instr_dat_out,
    output logic              stall_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ      = 2'd0,
        S_WAIT_RSP = 2'd1,
        S_HOLD     = 2'd2,
        S_DROP     = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic        hold_vld_q, hold_vld_d;
    logic [31:0] out_addr_q, out_addr_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_stall_q, out_stall_d;
    logic        req_valid;
    logic        req_fire;

    // Request valid per state; a redirect cycle never issues a request.
    always_comb begin
        req_valid = 1'b0;
        case (state_q)
            S_REQ:      req_valid = ~redirect_en;
            S_WAIT_RSP: req_valid = imem_rsp_valid & ~stall_in & ~redirect_en;
            default:    req_valid = 1'b0;
        endcase
    end

    assign req_fire       = req_valid & imem_req_ready;
    // State resets to REQ asynchronously, so valid must be masked during reset.
    assign imem_req_valid = req_valid & rst_n;
    assign imem_req_addr  = pc_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        hold_vld_d  = hold_vld_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_stall_d = out_stall_q;

        if (redirect_en) begin
            pc_d        = redirect_addr & 32'hFFFF_FFFC;
            hold_vld_d  = 1'b0;
            out_data_d  = NOP_INSTR;
            out_stall_d = 1'b1;
            case (state_q)
                S_REQ:      state_d = req_fire ? S_DROP : S_REQ;
                S_WAIT_RSP: state_d = imem_rsp_valid ? S_REQ : S_DROP;
                S_HOLD:     state_d = S_REQ;
                // A stale response landing in the redirect cycle retires
                // the outstanding request; otherwise keep waiting for it.
                default:    state_d = imem_rsp_valid ? S_REQ : S_DROP;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        req_addr_d = pc_q;
                        pc_d       = pc_q + 32'd4;
                        state_d    = S_WAIT_RSP;
                    end
                    if (!stall_in) begin
                        out_data_d  = NOP_INSTR;
                        out_stall_d = 1'b1;
                    end
                end
                S_WAIT_RSP: begin
                    if (imem_rsp_valid) begin
                        if (stall_in) begin
                            hold_addr_d = req_addr_q;
                            hold_data_d = imem_rsp_data;
                            hold_vld_d  = 1'b1;
                            state_d     = S_HOLD;
                        end else begin
                            out_addr_d  = req_addr_q;
                            out_data_d  = imem_rsp_data;
                            out_stall_d = 1'b0;
                            if (req_fire) begin
                                req_addr_d = pc_q;
                                pc_d       = pc_q + 32'd4;
                            end else begin
                                state_d = S_REQ;
                            end
                        end
                    end else if (!stall_in) begin
                        out_data_d  = NOP_INSTR;
                        out_stall_d = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!stall_in) begin
                        if (hold_vld_q) begin
                            out_addr_d  = hold_addr_q;
                            out_data_d  = hold_data_q;
                            out_stall_d = 1'b0;
                        end else begin
                            out_data_d  = NOP_INSTR;
                            out_stall_d = 1'b1;
                        end
                        hold_vld_d = 1'b0;
                        state_d    = S_REQ;
                    end
                end
                default: begin
                    if (imem_rsp_valid) begin
                        state_d = S_REQ;
                    end
                    if (!stall_in) begin
                        out_data_d  = NOP_INSTR;
                        out_stall_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            req_addr_q  <= '0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            hold_vld_q  <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= NOP_INSTR;
            out_stall_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            hold_vld_q  <= hold_vld_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_stall_q <= out_stall_d;
        end
    end

    assign f_out.instr_addr = out_addr_q;
    assign instr_dat_out    = out_data_q;
    assign stall_out        = out_stall_q;

`ifdef FETCH_PERF_CNT_EN
    // The output registers load whenever stall_in is low or a redirect forces
    // a bubble; the loaded stall bit tells valid loads from bubble loads.
    logic out_load;
    assign out_load = ~stall_in | redirect_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else if (out_load) begin
            if (out_stall_d) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end else begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch
//  Purpose  : Self-checking bench for fetch. Drives a bench-side memory with
//             per-request latency and tracks requests, staleness and the
//             instruction owed to decode at transaction level; checks the
//             DUT every cycle plus literal scenario expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_in = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    f_d_WI       f_out;
    logic [31:0] instr_dat_out;
    logic        stall_out;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    always #5 clk = ~clk;

    fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_in       (stall_in),
        .redirect_en    (redirect_en),
        .redirect_addr  (redirect_addr),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .f_out          (f_out),
        .instr_dat_out  (instr_dat_out),
        .stall_out      (stall_out)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    req_t        mq[$];
    logic [31:0] exp_pc;
    bit          pend_v;
    logic [31:0] pend_a, pend_d;
    logic [31:0] e_addr, e_data;
    logic        e_stall;
    int          e_fc, e_bc;
    int          cyc;
    logic        last_vld;
    logic [31:0] last_addr;
    int          n_chk = 0;
    int          n_pass = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_outputs();
        chk("out_addr", f_out.instr_addr, e_addr);
        chk("out_data", instr_dat_out, e_data);
        chk("out_stall", 32'(stall_out), 32'(e_stall));
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch", perf_fetch_cnt, 32'(e_fc));
        chk("perf_bubble", perf_bubble_cnt, 32'(e_bc));
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        stall_in = 1'b0; redirect_en = 1'b0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        mq.delete();
        exp_pc = 32'h0; pend_v = 0;
        e_addr = 32'h0; e_data = NOP; e_stall = 1'b1; e_fc = 0; e_bc = 0;
        cyc = 0;
        // reset acts without a clock edge
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk_outputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_req_valid", 32'(imem_req_valid), 32'd0);
        chk_outputs();
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, check the request side, advance the
    // transaction model, then check the registered outputs after the edge.
    task automatic step(input bit st, input bit rd, input logic [31:0] ra,
                        input bit rdy, input int lat);
        bit          arr_v;
        logic [31:0] arr_a, arr_d;
        bit          ev;
        req_t        r;
        @(negedge clk);
        stall_in = st; redirect_en = rd; redirect_addr = ra; imem_req_ready = rdy;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        if (rd)               ev = 0;
        else if (pend_v)      ev = 0;
        else if (mq.size() > 0) ev = imem_rsp_valid && !st && !mq[0].stale;
        else                  ev = 1;
        chk("req_valid", 32'(imem_req_valid), 32'(ev));
        chk("req_addr", imem_req_addr, exp_pc);
        last_vld  = imem_req_valid;
        last_addr = imem_req_addr;

        arr_v = 0; arr_a = '0; arr_d = '0;
        if (imem_rsp_valid) begin
            r = mq.pop_front();
            if (!r.stale && !rd) begin
                arr_v = 1; arr_a = r.addr; arr_d = mem_word(r.addr);
            end
        end
        if (rd) begin
            pend_v = 0;
            foreach (mq[i]) mq[i].stale = 1;
            exp_pc  = {ra[31:2], 2'b00};
            e_data  = NOP; e_stall = 1'b1;
        end else if (st) begin
            if (arr_v) begin pend_v = 1; pend_a = arr_a; pend_d = arr_d; end
        end else if (pend_v) begin
            e_addr = pend_a; e_data = pend_d; e_stall = 1'b0; pend_v = 0;
        end else if (arr_v) begin
            e_addr = arr_a; e_data = arr_d; e_stall = 1'b0;
        end else begin
            e_data = NOP; e_stall = 1'b1;
        end
        if (!st || rd) begin
            if (e_stall) e_bc++;
            else         e_fc++;
        end
        if (ev && rdy) begin
            mq.push_back('{exp_pc, cyc + lat, 1'b0});
            exp_pc = exp_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk_outputs();
    endtask

    initial begin
        // Reset, first fetch and streaming
        do_reset();
        step(0, 0, 0, 1, 1);
        chk("first_req_valid", 32'(last_vld), 32'd1);
        chk("first_req_addr", last_addr, 32'h0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 1, 1);
            chk("stream_addr", f_out.instr_addr, 32'(i * 4));
            chk("stream_stall", 32'(stall_out), 32'd0);
            if (i == 0) chk("first_data", instr_dat_out, mem_word(32'h0));
        end

        // Request backpressure
        do_reset();
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1);
            chk("bp_valid", 32'(last_vld), 32'd1);
            chk("bp_addr", last_addr, 32'h8);
            chk("bp_bubble", 32'(stall_out), 32'd1);
        end

        // Downstream stall over the response for 0x10
        do_reset();
        repeat (5) step(0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 1, 1);
            chk("hold_no_req", 32'(last_vld), 32'd0);
            chk("hold_frozen", f_out.instr_addr, 32'hC);
        end
        step(0, 0, 0, 1, 1);
        chk("hold_release_addr", f_out.instr_addr, 32'h10);
        chk("hold_release_stall", 32'(stall_out), 32'd0);

        // Redirect while waiting on a 3-cycle response
        do_reset();
        repeat (8) step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 3);
        chk("rw_req20", last_addr, 32'h20);
        step(0, 1, 32'h0000_0103, 1, 1);
        chk("rw_no_req", 32'(last_vld), 32'd0);
        chk("rw_bubble", 32'(stall_out), 32'd1);
        step(0, 0, 0, 1, 1);
        chk("rw_drop_addr", last_addr, 32'h100);
        step(0, 0, 0, 1, 1);
        chk("rw_discard", 32'(stall_out), 32'd1);
        step(0, 0, 0, 1, 1);
        chk("rw_new_req_v", 32'(last_vld), 32'd1);
        chk("rw_new_req_a", last_addr, 32'h100);
        step(0, 0, 0, 1, 1);
        chk("rw_present", f_out.instr_addr, 32'h100);

        // Redirect coincident with a response
        do_reset();
        repeat (3) step(0, 0, 0, 1, 1);
        step(0, 1, 32'h0000_0200, 1, 1);
        chk("rc_bubble", 32'(stall_out), 32'd1);
        chk("rc_addr_kept", f_out.instr_addr, 32'h4);
        step(0, 0, 0, 1, 1);
        chk("rc_req", last_addr, 32'h200);
        step(0, 0, 0, 1, 1);
        chk("rc_present", f_out.instr_addr, 32'h200);

        // Randomized traffic, with resets in the middle of activity
        for (int blk = 0; blk < 3; blk++) begin
            do_reset();
            for (int i = 0; i < 1500; i++) begin
                logic [31:0] ra;
                ra = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
                step(($urandom % 4) == 0, ($urandom % 16) == 0, ra,
                     ($urandom % 4) != 0, int'($urandom_range(1, 3)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
